// File: rtl/dmx_output_frame_tx.sv
// -----------------------------------------------------------------------------
// dmx_output_frame_tx
//
// DMX512 frame transmitter. A start pulse sends one frame on the line:
// Break, Mark-After-Break, the start code (slot 0), then n_slots data slots.
// Each slot is 8N2 at BAUD_RATE. Slot bytes come from a synchronous EBR read
// port; address 0 holds the start code.
//
// Optional feature (compile-time macro DMX_AUTO_REFRESH_EN):
//   The first accepted start arms continuous output. A new frame then begins
//   every REFRESH_US, or one cycle after DONE when a frame outlasts the
//   period. Only rst_n disarms it. When the macro is undefined, frames are
//   sent only on start pulses and the period counter is not built.
//
// Ports:
//   clk                in   1   system clock
//   rst_n              in   1   synchronous reset, active-low
//   start              in   1   1-cycle pulse requesting one frame
//   n_slots            in  10   data slots after the start code, clamped to MAX_SLOTS
//   rd_addr            out  9   EBR read address (slot index, low 9 bits)
//   rd_data            in   8   EBR read data, valid one clock after rd_addr
//   DMX_Output_Signal  out  1   line data, idle/mark = 1
//   DE                 out  1   RS-485 driver enable
//   busy               out  1   high from accepted start until frame_done
//   frame_done         out  1   1-cycle pulse after the last stop bit
// -----------------------------------------------------------------------------
module dmx_output_frame_tx #(
   parameter int unsigned CLK_FREQ  = 20_000_000,
   parameter int unsigned BAUD_RATE = 250_000,
   parameter int unsigned BREAK_US  = 176,
   parameter int unsigned MAB_US    = 12,
   parameter int unsigned MAX_SLOTS = 512
`ifdef DMX_AUTO_REFRESH_EN
   ,
   parameter int unsigned REFRESH_US = 25_000
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [9:0] n_slots,
   output logic [8:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       DMX_Output_Signal,
   output logic       DE,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned BIT_TICKS   = CLK_FREQ / BAUD_RATE;
   localparam int unsigned BREAK_TICKS = (CLK_FREQ / 1_000_000) * BREAK_US;
   localparam int unsigned MAB_TICKS   = (CLK_FREQ / 1_000_000) * MAB_US;

   localparam logic [11:0] BIT_LAST    = 12'(BIT_TICKS - 1);
   localparam logic [11:0] BREAK_LAST  = 12'(BREAK_TICKS - 1);
   localparam logic [11:0] MAB_LAST    = 12'(MAB_TICKS - 1);
   localparam logic [9:0]  MAX_SLOTS_V = 10'(MAX_SLOTS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BREAK,
      S_MAB,
      S_FETCH,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t      state_q,    state_d;
   logic [11:0] tick_q,     tick_d;
   logic [3:0]  bit_q,      bit_d;
   logic [9:0]  slot_q,     slot_d;
   logic [9:0]  nslots_q,   nslots_d;
   logic        fetch_ph_q, fetch_ph_d;
   logic [10:0] shift_q,    shift_d;
   logic        line_q,     line_d;
   logic        de_q,       de_d;
   logic        busy_q,     busy_d;
   logic        done_q,     done_d;
   logic [8:0]  rd_addr_q,  rd_addr_d;

   logic [9:0]  slot_inc;
   logic        auto_go;

   // Saturate the requested slot count to the configured maximum.
   function automatic logic [9:0] clamp_slots(input logic [9:0] n);
      return (n > MAX_SLOTS_V) ? MAX_SLOTS_V : n;
   endfunction

   assign slot_inc = slot_q + 10'd1;

`ifdef DMX_AUTO_REFRESH_EN
   localparam int unsigned REFRESH_TICKS = (CLK_FREQ / 1_000_000) * REFRESH_US;
   localparam logic [19:0] REFRESH_LAST  = 20'(REFRESH_TICKS - 1);

   logic        armed_q,  armed_d;
   logic [19:0] period_q, period_d;

   // Period elapsed while armed. The counter saturates, so a frame that
   // outlasts the period still leaves this asserted when DONE is reached.
   assign auto_go = armed_q && (period_q >= REFRESH_LAST);

   always_comb begin
      armed_d  = armed_q;
      period_d = period_q;
      if (state_q == S_IDLE && start) begin
         armed_d = 1'b1;
      end
      if (state_d == S_BREAK && state_q != S_BREAK) begin
         period_d = '0;
      end else if (period_q < REFRESH_LAST) begin
         period_d = period_q + 20'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         armed_q  <= 1'b0;
         period_q <= '0;
      end else begin
         armed_q  <= armed_d;
         period_q <= period_d;
      end
   end
`else
   assign auto_go = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      bit_d      = bit_q;
      slot_d     = slot_q;
      nslots_d   = nslots_q;
      fetch_ph_d = fetch_ph_q;
      shift_d    = shift_q;
      line_d     = line_q;
      de_d       = de_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rd_addr_d  = rd_addr_q;

      unique case (state_q)
         S_IDLE: begin
            line_d = 1'b1;
            de_d   = 1'b0;
            busy_d = 1'b0;
            if (start || auto_go) begin
               state_d  = S_BREAK;
               tick_d   = '0;
               nslots_d = clamp_slots(n_slots);
               line_d   = 1'b0;
               de_d     = 1'b1;
               busy_d   = 1'b1;
            end
         end

         S_BREAK: begin
            tick_d = tick_q + 12'd1;
            if (tick_q == BREAK_LAST) begin
               state_d = S_MAB;
               tick_d  = '0;
               line_d  = 1'b1;
            end
         end

         S_MAB: begin
            tick_d = tick_q + 12'd1;
            if (tick_q == MAB_LAST) begin
               state_d    = S_FETCH;
               tick_d     = '0;
               slot_d     = '0;
               rd_addr_d  = '0;
               fetch_ph_d = 1'b0;
            end
         end

         // Phase 0: address is on the EBR port. Phase 1: data is valid and is
         // loaded as {stop, stop, d[7:0], start} so bit 0 is always on the line.
         S_FETCH: begin
            if (!fetch_ph_q) begin
               fetch_ph_d = 1'b1;
            end else begin
               state_d = S_SHIFT;
               shift_d = {2'b11, rd_data, 1'b0};
               line_d  = 1'b0;
               bit_d   = '0;
               tick_d  = '0;
            end
         end

         S_SHIFT: begin
            tick_d = tick_q + 12'd1;
            if (tick_q == BIT_LAST) begin
               tick_d = '0;
               if (bit_q == 4'd10) begin
                  line_d = 1'b1;
                  if (slot_q == nslots_q) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     de_d    = 1'b0;
                  end else begin
                     state_d    = S_FETCH;
                     slot_d     = slot_inc;
                     rd_addr_d  = slot_inc[8:0];
                     fetch_ph_d = 1'b0;
                  end
               end else begin
                  bit_d   = bit_q + 4'd1;
                  shift_d = {1'b1, shift_q[10:1]};
                  line_d  = shift_q[1];
               end
            end
         end

         // An external start here is ignored; only an expired refresh
         // period chains straight into the next Break.
         S_DONE: begin
            state_d = S_IDLE;
            if (auto_go) begin
               state_d  = S_BREAK;
               tick_d   = '0;
               nslots_d = clamp_slots(n_slots);
               line_d   = 1'b0;
               de_d     = 1'b1;
               busy_d   = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         slot_q     <= '0;
         nslots_q   <= '0;
         fetch_ph_q <= 1'b0;
         line_q     <= 1'b1;
         de_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         slot_q     <= slot_d;
         nslots_q   <= nslots_d;
         fetch_ph_q <= fetch_ph_d;
         line_q     <= line_d;
         de_q       <= de_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_addr_q  <= rd_addr_d;
      end
   end

   // Slot data shift register; always reloaded before use, so no reset.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   assign rd_addr           = rd_addr_q;
   assign DMX_Output_Signal = line_q;
   assign DE                = de_q;
   assign busy              = busy_q;
   assign frame_done        = done_q;

endmodule

// File: tb/tb_dmx_output_frame_tx.sv
module tb_dmx_output_frame_tx;

   // Scaled timing keeps the bench short: 2 MHz clock gives 8 clks/bit,
   // a 352-clk Break and a 24-clk MAB.
   localparam int CLK_FREQ  = 2_000_000;
   localparam int BAUD_RATE = 250_000;
   localparam int BREAK_US  = 176;
   localparam int MAB_US    = 12;
   localparam int MAX_SLOTS = 512;
   localparam int BIT   = CLK_FREQ / BAUD_RATE;
   localparam int BRK   = (CLK_FREQ / 1_000_000) * BREAK_US;
   localparam int MAB   = (CLK_FREQ / 1_000_000) * MAB_US;
   localparam int SLOT  = 2 + 11 * BIT;
`ifdef DMX_AUTO_REFRESH_EN
   localparam int REFRESH_US = 2000;
   localparam int REF = (CLK_FREQ / 1_000_000) * REFRESH_US;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [9:0] n_slots;
   logic [8:0] rd_addr;
   logic [7:0] rd_data;
   logic       line;
   logic       de;
   logic       busy;
   logic       frame_done;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [512];
   logic ln_s[$];
   logic fd_s[$];
   logic de_s[$];
   logic bs_s[$];
   logic [8:0] ad_s[$];

   always #5 clk = ~clk;

   // Synchronous EBR read port model
   always @(posedge clk) rd_data <= mem[rd_addr];

   dmx_output_frame_tx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD_RATE),
      .BREAK_US (BREAK_US),
      .MAB_US   (MAB_US),
      .MAX_SLOTS(MAX_SLOTS)
`ifdef DMX_AUTO_REFRESH_EN
      ,
      .REFRESH_US(REFRESH_US)
`endif
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .n_slots          (n_slots),
      .rd_addr          (rd_addr),
      .rd_data          (rd_data),
      .DMX_Output_Signal(line),
      .DE               (de),
      .busy             (busy),
      .frame_done       (frame_done)
   );

   // Pulse start with n slots, then log outputs for 'cycles' clocks.
   // Sample 0 is the first clock after the accepting edge. Extra start
   // pulses are raised right after samples pa and pb.
   task automatic capture(input int n, input int cycles, input int pa, input int pb);
      ln_s.delete(); fd_s.delete(); de_s.delete(); bs_s.delete(); ad_s.delete();
      @(negedge clk);
      n_slots = 10'(n);
      start   = 1'b1;
      for (int j = 0; j < cycles; j++) begin
         @(negedge clk);
         ln_s.push_back(line);
         fd_s.push_back(frame_done);
         de_s.push_back(de);
         bs_s.push_back(busy);
         ad_s.push_back(rd_addr);
         start = (j == pa || j == pb) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
   endtask

   function automatic int frame_len(input int n);
      int ne;
      ne = (n > MAX_SLOTS) ? MAX_SLOTS : n;
      return BRK + MAB + (ne + 1) * SLOT;
   endfunction

   // Compare the logged frame against the ideal DMX waveform built from
   // the frame rules and the EBR contents.
   task automatic check_frame(input string tag, input int n);
      int ne, nf, len, base, fd_first, fd_cnt, tail_bad;
      logic [7:0] got, exp;
      logic fr_ok;
      ne = (n > MAX_SLOTS) ? MAX_SLOTS : n;
      nf = frame_len(n);

      len = 0;
      while (len < ln_s.size() && ln_s[len] === 1'b0) len++;
      total++;
      if (len !== BRK) begin
         bad++;
         $display("FAIL %s break_len: got %0d want %0d", tag, len, BRK);
      end

      len = 0;
      while (BRK + len < ln_s.size() && ln_s[BRK + len] === 1'b1) len++;
      total++;
      if (len !== MAB + 2) begin
         bad++;
         $display("FAIL %s mark_before_slot0: got %0d want %0d", tag, len, MAB + 2);
      end

      for (int k = 0; k <= ne; k++) begin
         base  = BRK + MAB + 2 + k * SLOT;
         fr_ok = (ln_s[base - 1] === 1'b1) && (ln_s[base] === 1'b0) &&
                 (ln_s[base + BIT / 2] === 1'b0) &&
                 (ln_s[base + 9 * BIT + BIT / 2] === 1'b1) &&
                 (ln_s[base + 10 * BIT + BIT / 2] === 1'b1) &&
                 (ln_s[base + 11 * BIT - 1] === 1'b1);
         for (int b = 0; b < 8; b++) got[b] = ln_s[base + (b + 1) * BIT + BIT / 2];
         exp = mem[k % 512];
         total++;
         if ({fr_ok, got} !== {1'b1, exp}) begin
            bad++;
            $display("FAIL %s slot%0d: got byte %02h framing %0b want byte %02h framing 1",
                     tag, k, got, fr_ok, exp);
         end
         total++;
         if (ad_s[base - 2] !== 9'(k % 512)) begin
            bad++;
            $display("FAIL %s rd_addr slot%0d: got %0d want %0d", tag, k, ad_s[base - 2], k % 512);
         end
      end

      fd_first = -1;
      fd_cnt   = 0;
      for (int j = 0; j < fd_s.size(); j++) begin
         if (fd_s[j] !== 1'b0) begin
            fd_cnt++;
            if (fd_first < 0) fd_first = j;
         end
      end
      total++;
      if (fd_first !== nf || fd_cnt !== 1) begin
         bad++;
         $display("FAIL %s frame_done: got first=%0d count=%0d want first=%0d count=1",
                  tag, fd_first, fd_cnt, nf);
      end

      total++;
      if ({de_s[nf - 1], bs_s[nf - 1], de_s[nf], bs_s[nf]} !== 4'b1100) begin
         bad++;
         $display("FAIL %s de_busy_end: got %b want 1100", tag,
                  {de_s[nf - 1], bs_s[nf - 1], de_s[nf], bs_s[nf]});
      end

      tail_bad = 0;
      for (int j = nf; j < ln_s.size(); j++)
         if (ln_s[j] !== 1'b1 || bs_s[j] !== 1'b0 || de_s[j] !== 1'b0) tail_bad++;
      total++;
      if (tail_bad !== 0) begin
         bad++;
         $display("FAIL %s idle_after_frame: got %0d bad samples want 0", tag, tail_bad);
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      start   = 1'b0;
      n_slots = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({line, de, busy, frame_done, rd_addr} !== {4'b1000, 9'd0}) begin
         bad++;
         $display("FAIL reset_state: got line=%b de=%b busy=%b fd=%b addr=%0d want 1 0 0 0 0",
                  line, de, busy, frame_done, rd_addr);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      mem[0] = 8'h00; mem[1] = 8'hAA; mem[2] = 8'h55;
      capture(2, frame_len(2) + 20, -1, -1);
      check_frame("basic", 2);
   endtask

   task automatic test_start_ignored();
      int nf;
      for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
      nf = frame_len(2);
      // One pulse mid-frame, one in the same clock as frame_done
      capture(2, nf + 40, BRK + MAB + SLOT + 30, nf);
      check_frame("start_ignored", 2);
   endtask

   task automatic test_random_frames();
      int n;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
         n = $urandom_range(0, 6);
         capture(n, frame_len(n) + 20, -1, -1);
         check_frame($sformatf("rand%0d_n%0d", r, n), n);
      end
   endtask

   task automatic test_clamp();
      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
      capture(600, frame_len(600) + 20, -1, -1);
      check_frame("clamp600", 600);
   endtask

   task automatic test_reset_mid();
      int target;
      for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
      target = BRK + MAB + 2 + SLOT + 4 * BIT + BIT / 2;
      @(negedge clk);
      n_slots = 10'd3;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (target) @(negedge clk);
      total++;
      if ({busy, de} !== 2'b11) begin
         bad++;
         $display("FAIL mid_frame_active: got busy=%b de=%b want 1 1", busy, de);
      end
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if ({line, de, busy, frame_done, rd_addr} !== {4'b1000, 9'd0}) begin
         bad++;
         $display("FAIL reset_mid_frame: got line=%b de=%b busy=%b fd=%b addr=%0d want 1 0 0 0 0",
                  line, de, busy, frame_done, rd_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      capture(3, frame_len(3) + 20, -1, -1);
      check_frame("after_reset", 3);
   endtask

`ifdef DMX_AUTO_REFRESH_EN
   task automatic test_auto_refresh();
      int brk[$];
      int dn[$];
      int run;
      int win;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 61; i++) mem[i] = 8'($urandom);
      win = 4 * REF + frame_len(60) + 2000;
      ln_s.delete(); fd_s.delete();
      @(negedge clk);
      n_slots = 10'd24;
      start   = 1'b1;
      for (int j = 0; j < win; j++) begin
         @(negedge clk);
         start = 1'b0;
         ln_s.push_back(line);
         fd_s.push_back(frame_done);
         if (j == 3 * REF + frame_len(24) + 100) n_slots = 10'd60;
      end
      for (int j = 0; j < ln_s.size(); j++) begin
         if (fd_s[j] === 1'b1) dn.push_back(j);
         if (ln_s[j] === 1'b0 && (j == 0 || ln_s[j - 1] === 1'b1)) begin
            run = 0;
            while (j + run < ln_s.size() && ln_s[j + run] === 1'b0) run++;
            if (run >= BRK) brk.push_back(j);
         end
      end
      total++;
      if (brk.size() < 6 || dn.size() < 5) begin
         bad++;
         $display("FAIL auto_frame_count: got breaks=%0d dones=%0d want >=6 >=5",
                  brk.size(), dn.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (brk[i + 1] - brk[i] !== REF) begin
               bad++;
               $display("FAIL auto_period%0d: got %0d want %0d", i, brk[i + 1] - brk[i], REF);
            end
            total++;
            if (dn[i] - brk[i] !== frame_len(24)) begin
               bad++;
               $display("FAIL auto_len%0d: got %0d want %0d", i, dn[i] - brk[i], frame_len(24));
            end
         end
         total++;
         if (dn[4] - brk[4] !== frame_len(60)) begin
            bad++;
            $display("FAIL auto_long_len: got %0d want %0d", dn[4] - brk[4], frame_len(60));
         end
         total++;
         if (brk[5] !== dn[4] + 1) begin
            bad++;
            $display("FAIL auto_overrun_restart: got %0d want %0d", brk[5], dn[4] + 1);
         end
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      test_reset();
      test_basic();
      test_start_ignored();
      test_random_frames();
      test_reset_mid();
`ifdef DMX_AUTO_REFRESH_EN
      test_auto_refresh();
`else
      test_clamp();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
